// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: op encodings and arbiter FSM states.
// Optional divide-by-zero error flag is controlled by ALU_ARB_DIV_ZERO_ERR_EN in alu_arbiter.
package alu_pkg;

  localparam int W_ALU_SEL = 3;

  typedef enum logic [W_ALU_SEL-1:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_DIV = 3'd3,
    ALU_MOD = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu.sv
// Combinational signed ALU; results wrap to WIDTH bits, DIV/MOD by zero return 0.
// Encodings outside alu_op_e pass operand a through.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic signed [WIDTH-1:0] alu_a,
  input  logic signed [WIDTH-1:0] alu_b,
  input  alu_op_e                 alu_sel,
  output logic signed [WIDTH-1:0] alu_result
);

  logic signed [2*WIDTH-1:0] w_prod;
  logic signed [WIDTH-1:0]   w_quot;
  logic signed [WIDTH-1:0]   w_rem;
  logic                      w_b_zero;

  // Quotient/remainder are computed as signed values before the zero guard so
  // the guard's unsigned constant cannot turn the division unsigned.
  assign w_prod   = alu_a * alu_b;
  assign w_quot   = alu_a / alu_b;
  assign w_rem    = alu_a % alu_b;
  assign w_b_zero = (alu_b == '0);

  always_comb begin
    alu_result = alu_a;
    case (alu_sel)
      ALU_ADD: alu_result = alu_a + alu_b;
      ALU_SUB: alu_result = alu_a - alu_b;
      ALU_MUL: alu_result = w_prod[WIDTH-1:0];
      ALU_DIV: alu_result = w_b_zero ? '0 : w_quot;
      ALU_MOD: alu_result = w_b_zero ? '0 : w_rem;
      default: alu_result = alu_a;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one signed ALU among N_REQ requesters, one op in flight.
// Define ALU_ARB_DIV_ZERO_ERR_EN to register a divide/modulo-by-zero flag on rsp_err.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter int  N_REQ = 2,
  localparam int W_ID  = $clog2(N_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  input  logic [N_REQ*W_ALU_SEL-1:0] req_sel,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_ready,
  output logic signed [WIDTH-1:0]    rsp_data,
  output logic                       rsp_zero,
  output logic                       rsp_negative,
  output logic                       rsp_err,
  output logic                       busy,
  output logic [W_ID-1:0]            grant_id
);

  arb_state_e              r_state;
  arb_state_e              w_state_nxt;
  logic [W_ID-1:0]         r_rr_ptr;
  logic [W_ID-1:0]         r_grant;
  logic [W_ID-1:0]         w_win;
  logic                    w_found;
  logic                    w_accept;
  logic                    w_rsp_done;
  int                      w_idx;
  logic signed [WIDTH-1:0] r_a;
  logic signed [WIDTH-1:0] r_b;
  logic [W_ALU_SEL-1:0]    r_sel;
  logic signed [WIDTH-1:0] w_win_a;
  logic signed [WIDTH-1:0] w_win_b;
  logic [W_ALU_SEL-1:0]    w_win_sel;
  logic signed [WIDTH-1:0] w_alu_res;
  logic signed [WIDTH-1:0] r_data;
  logic                    r_zero;
  logic                    r_neg;

  // Search starts one past the last granted requester, wrapping modulo N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_rr_ptr;
    w_idx   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && req_valid[W_ID'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = W_ID'(w_idx);
      end
    end
  end

  always_comb begin
    w_win_a   = '0;
    w_win_b   = '0;
    w_win_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == W_ID'(i)) begin
        w_win_a   = req_a[i*WIDTH +: WIDTH];
        w_win_b   = req_b[i*WIDTH +: WIDTH];
        w_win_sel = req_sel[i*W_ALU_SEL +: W_ALU_SEL];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = '0;
    rsp_valid   = '0;
    w_accept    = 1'b0;
    w_rsp_done  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found && !rst) begin
          req_ready[w_win] = 1'b1;
          w_accept         = 1'b1;
          w_state_nxt      = EXEC;
        end
      end
      EXEC: w_state_nxt = RESP;
      RESP: begin
        rsp_valid[r_grant] = 1'b1;
        if (rsp_ready[r_grant]) begin
          w_rsp_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .alu_a     (r_a),
    .alu_b     (r_b),
    .alu_sel   (alu_op_e'(r_sel)),
    .alu_result(w_alu_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= W_ID'(N_REQ - 1);
      r_grant  <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_sel    <= '0;
      r_data   <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_a     <= w_win_a;
        r_b     <= w_win_b;
        r_sel   <= w_win_sel;
        r_grant <= w_win;
      end
      if (r_state == EXEC) begin
        r_data <= w_alu_res;
        r_zero <= (w_alu_res == '0);
        r_neg  <= w_alu_res[WIDTH-1];
      end
      if (w_rsp_done) r_rr_ptr <= r_grant;
    end
  end

`ifdef ALU_ARB_DIV_ZERO_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == EXEC) begin
      r_err <= ((r_sel == ALU_DIV) || (r_sel == ALU_MOD)) && (r_b == '0);
    end
  end

  assign rsp_err = r_err;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_data     = r_data;
  assign rsp_zero     = r_zero;
  assign rsp_negative = r_neg;
  assign busy         = (r_state != IDLE);
  assign grant_id     = r_grant;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (WIDTH=8, N_REQ=2).
// Expected rsp_err for divide-by-zero follows ALU_ARB_DIV_ZERO_ERR_EN.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [5:0]  req_sel;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_zero;
  logic        rsp_negative;
  logic        rsp_err;
  logic        busy;
  logic [0:0]  grant_id;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef ALU_ARB_DIV_ZERO_ERR_EN
  localparam logic EXP_DZ_ERR = 1'b1;
`else
  localparam logic EXP_DZ_ERR = 1'b0;
`endif

  alu_arbiter #(.WIDTH(8), .N_REQ(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sel     (req_sel),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_zero    (rsp_zero),
    .rsp_negative(rsp_negative),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel);
    req_a[id*8 +: 8]   = a;
    req_b[id*8 +: 8]   = b;
    req_sel[id*3 +: 3] = sel;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_sel = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one op from requester id and collects its response (bounded waits).
  task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                        output logic [7:0] d, output logic z, output logic n, output logic e,
                        output logic tmo);
    int k;
    tmo = 1'b0;
    @(negedge clk);
    set_req(id, a, b, sel);
    req_valid[id] = 1'b1;
    #1;
    k = 0;
    while (!req_ready[id] && k < 10) begin @(negedge clk); #1; k++; end
    if (!req_ready[id]) tmo = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid[id] = 1'b0;
    k = 0;
    while (!rsp_valid[id] && k < 10) begin @(negedge clk); k++; end
    if (!rsp_valid[id]) tmo = 1'b1;
    d = rsp_data; z = rsp_zero; n = rsp_negative; e = rsp_err;
    rsp_ready[id] = 1'b1;
    @(negedge clk);
    rsp_ready[id] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_sel = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 00", rsp_data); end
    n_checks++; if ({rsp_zero, rsp_negative, rsp_err} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {rsp_zero, rsp_negative, rsp_err}); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant_id); end
    rst = 1'b0;
  endtask

  task automatic test_add();
    do_reset();
    @(negedge clk);
    set_req(0, 8'd5, 8'd3, 3'd0);
    req_valid = 2'b01;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL add_ready_same_cycle: got %b want 01", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_idle: got %b want 0", busy); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_exec: got %b want 1", busy); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL add_rsp_early: got %b want 00", rsp_valid); end
    @(negedge clk);
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL add_rsp_valid_T2: got %b want 01", rsp_valid); end
    n_checks++; if (rsp_data !== 8'd8) begin n_fail++; $display("FAIL add_data: got %0d want 8", rsp_data); end
    n_checks++; if ({rsp_zero, rsp_negative} !== 2'b00) begin n_fail++; $display("FAIL add_flags: got %b want 00", {rsp_zero, rsp_negative}); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL add_busy_resp: got %b want 1", busy); end
    rsp_ready = 2'b01;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_done: got %b want 0", busy); end
    n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL add_rsp_cleared: got %b want 00", rsp_valid); end
    rsp_ready = 2'b00;
  endtask

  task automatic test_round_robin();
    logic [0:0] exp_id;
    int k;
    @(negedge clk);
    rst = 1'b1; rsp_ready = 2'b11;
    set_req(0, 8'd3, 8'd5, 3'd1);
    set_req(1, 8'd4, 8'hFE, 3'd2);
    req_valid = 2'b11;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int op = 0; op < 4; op++) begin
      exp_id = op[0:0];
      k = 0;
      while (rsp_valid === 2'b00 && k < 10) begin @(negedge clk); k++; end
      n_checks++; if (rsp_valid !== (2'b01 << exp_id)) begin n_fail++; $display("FAIL rr_rsp_valid op%0d: got %b want %b", op, rsp_valid, 2'b01 << exp_id); end
      n_checks++; if (grant_id !== exp_id) begin n_fail++; $display("FAIL rr_grant op%0d: got %0d want %0d", op, grant_id, exp_id); end
      n_checks++; if (rsp_data !== (exp_id ? 8'hF8 : 8'hFE)) begin n_fail++; $display("FAIL rr_data op%0d: got %h want %h", op, rsp_data, exp_id ? 8'hF8 : 8'hFE); end
      n_checks++; if (rsp_negative !== 1'b1) begin n_fail++; $display("FAIL rr_negative op%0d: got %b want 1", op, rsp_negative); end
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_alu_ops();
    logic [7:0] va [8] = '{8'd127, 8'd16, 8'hFB, 8'hF9, 8'hF9, 8'd9,  8'hF9, 8'h80};
    logic [7:0] vb [8] = '{8'd1,   8'd16, 8'd3,  8'd2,  8'd2,  8'd0,  8'd0,  8'd1};
    logic [2:0] vs [8] = '{3'd0,   3'd2,  3'd6,  3'd3,  3'd4,  3'd3,  3'd4,  3'd1};
    logic [7:0] vd [8] = '{8'h80,  8'h00, 8'hFB, 8'hFD, 8'hFF, 8'h00, 8'h00, 8'h7F};
    logic       vz [8] = '{1'b0,   1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0};
    logic       vn [8] = '{1'b1,   1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
    logic       ve [8];
    logic [7:0] d;
    logic       z, n, e, tmo;
    ve = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, EXP_DZ_ERR, EXP_DZ_ERR, 1'b0};
    do_reset();
    for (int v = 0; v < 8; v++) begin
      run_op(0, va[v], vb[v], vs[v], d, z, n, e, tmo);
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL alu_timeout v%0d: handshake not seen", v); end
      n_checks++; if (d !== vd[v]) begin n_fail++; $display("FAIL alu_data v%0d: got %h want %h", v, d, vd[v]); end
      n_checks++; if ({z, n} !== {vz[v], vn[v]}) begin n_fail++; $display("FAIL alu_flags v%0d: got zn=%b want %b", v, {z, n}, {vz[v], vn[v]}); end
      n_checks++; if (e !== ve[v]) begin n_fail++; $display("FAIL alu_err v%0d: got %b want %b", v, e, ve[v]); end
    end
  endtask

  task automatic test_back_to_back_stall();
    do_reset();
    @(negedge clk);
    set_req(0, 8'd2, 8'd7, 3'd1);
    set_req(1, 8'd10, 8'd20, 3'd0);
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL stall_first_grant: got %b want 01", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b10;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL stall_rsp_valid: got %b want 01", rsp_valid); end
    rsp_ready = 2'b10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      n_checks++; if ({rsp_valid, rsp_data, rsp_zero, rsp_negative} !== {2'b01, 8'hFB, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL stall_hold c%0d: got v=%b d=%h z=%b n=%b want v=01 d=fb z=0 n=1", c, rsp_valid, rsp_data, rsp_zero, rsp_negative);
      end
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_req_ready c%0d: got %b want 00", c, req_ready); end
    end
    rsp_ready = 2'b01;
    @(negedge clk);
    #1;
    n_checks++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL stall_next_grant: got %b want 10", req_ready); end
    rsp_ready = 2'b00;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL stall_req1_rsp: got %b want 10", rsp_valid); end
    n_checks++; if (rsp_data !== 8'd30) begin n_fail++; $display("FAIL stall_req1_data: got %0d want 30", rsp_data); end
    n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL stall_req1_grant: got %0d want 1", grant_id); end
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid_op();
    logic [7:0] d;
    logic       z, n, e, tmo;
    int         seen;
    do_reset();
    run_op(0, 8'd1, 8'd2, 3'd0, d, z, n, e, tmo);
    n_checks++; if ({tmo, d} !== {1'b0, 8'd3}) begin n_fail++; $display("FAIL rstmid_pre_op: got tmo=%b d=%0d want tmo=0 d=3", tmo, d); end
    @(negedge clk);
    set_req(1, 8'd4, 8'd4, 3'd0);
    req_valid = 2'b10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    n_checks++; if ({busy, grant_id} !== 2'b11) begin n_fail++; $display("FAIL rstmid_exec: got busy=%b grant=%0d want busy=1 grant=1", busy, grant_id); end
    rst = 1'b1;
    rsp_ready = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if ({busy, grant_id, rsp_valid, req_ready} !== 6'b0_0_00_00) begin
      n_fail++; $display("FAIL rstmid_outputs: got busy=%b grant=%0d rv=%b rr=%b want all 0", busy, grant_id, rsp_valid, req_ready);
    end
    n_checks++; if ({rsp_data, rsp_zero, rsp_negative, rsp_err} !== 11'd0) begin
      n_fail++; $display("FAIL rstmid_rsp_regs: got d=%h z=%b n=%b e=%b want all 0", rsp_data, rsp_zero, rsp_negative, rsp_err);
    end
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid !== 2'b00) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_no_response: got %0d rsp_valid cycles want 0", seen); end
    rsp_ready = 2'b00;
    set_req(0, 8'd6, 8'd1, 3'd1);
    req_valid = 2'b11;
    #1;
    n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_req0_wins: got %b want 01", req_ready); end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++; if ({rsp_valid, rsp_data} !== {2'b01, 8'd5}) begin n_fail++; $display("FAIL rstmid_req0_rsp: got v=%b d=%0d want v=01 d=5", rsp_valid, rsp_data); end
    rsp_ready = 2'b01;
    @(negedge clk);
    rsp_ready = 2'b00;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0; req_sel = '0;
    test_reset();
    test_add();
    test_round_robin();
    test_alu_ops();
    test_back_to_back_stall();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
